pipe_stage_buffer: RTL and testbench

// - Generic elastic pipeline register for the MIPS core: a DEPTH-slot chain of valid/ctrl/data registers between two stages.
// - Replaces the fixed inter-stage registers; ready/valid backpressure replaces the implicit always-advance model.
// - Keeps the debug-unit step gating and the bubble-on-flush semantics (ctrl cleared, data kept).

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/pipe_stage_slot.sv | 48 ++++
 rtl/pipe_stage_buffer.sv | 129 ++++++++++++
 tb/tb_pipe_stage_buffer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared widths, bubble constant and count-width helper for the elastic pipeline registers.
package pipe_pkg;

    localparam int NB_CTRL_DEFAULT = 16;
    localparam int NB_DATA_DEFAULT = 96;

    localparam int NB_CTRL_IF_ID  = 8;
    localparam int NB_DATA_IF_ID  = 64;
    localparam int NB_CTRL_ID_EX  = 16;
    localparam int NB_DATA_ID_EX  = 128;
    localparam int NB_CTRL_EX_MEM = 12;
    localparam int NB_DATA_EX_MEM = 96;
    localparam int NB_CTRL_MEM_WB = 4;
    localparam int NB_DATA_MEM_WB = 64;

    localparam logic [63:0] CTRL_BUBBLE = '0;

    function automatic int count_width(input int depth);
        return $clog2(depth + 2);
    endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// One valid/ctrl/data register slot; a bubble clears valid and ctrl but keeps the data payload.
module pipe_stage_slot
    import pipe_pkg::*;
#(
    parameter int NB_CTRL = NB_CTRL_DEFAULT,
    parameter int NB_DATA = NB_DATA_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic               i_bubble,
    input  logic               i_valid,
    input  logic [NB_CTRL-1:0] i_ctrl,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_valid,
    output logic [NB_CTRL-1:0] o_ctrl,
    output logic [NB_DATA-1:0] o_data
);

    logic               r_valid;
    logic [NB_CTRL-1:0] r_ctrl;
    logic [NB_DATA-1:0] r_data;

    // An empty load behaves like a bubble so stale data never needs to be rewritten.
    always_ff @(negedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
        end else if (i_bubble) begin
            r_valid <= 1'b0;
            r_ctrl  <= NB_CTRL'(CTRL_BUBBLE);
        end else if (i_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_ctrl <= i_ctrl;
                r_data <= i_data;
            end else begin
                r_ctrl <= NB_CTRL'(CTRL_BUBBLE);
            end
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_buffer.sv
// Elastic DEPTH-slot pipeline register with ready/valid backpressure, debug step gating and flush.
// Optional input skid entry enabled by defining PIPE_STAGE_SKID_EN.
module pipe_stage_buffer
    import pipe_pkg::*;
#(
    parameter int NB_CTRL = NB_CTRL_DEFAULT,
    parameter int NB_DATA = NB_DATA_DEFAULT,
    parameter int DEPTH   = 1
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_step,
    input  logic                          i_flush,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [NB_CTRL-1:0]            i_ctrl,
    input  logic [NB_DATA-1:0]            i_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [NB_CTRL-1:0]            o_ctrl,
    output logic [NB_DATA-1:0]            o_data,
    output logic [count_width(DEPTH)-1:0] o_count
);

    localparam int NB_COUNT = count_width(DEPTH);

    logic [DEPTH-1:0]   w_slotValid;
    logic [NB_CTRL-1:0] w_slotCtrl [DEPTH];
    logic [NB_DATA-1:0] w_slotData [DEPTH];
    logic [DEPTH-1:0]   w_adv;
    logic [DEPTH-1:0]   w_srcValid;
    logic [NB_CTRL-1:0] w_srcCtrl [DEPTH];
    logic [NB_DATA-1:0] w_srcData [DEPTH];
    logic               w_inValid;
    logic [NB_CTRL-1:0] w_inCtrl;
    logic [NB_DATA-1:0] w_inData;
    logic               w_skidValid;
    logic [NB_COUNT-1:0] w_count;

    // A slot may move forward when it is empty or its successor is moving; the tail watches i_ready.
    always_comb begin
        w_adv = '0;
        w_adv[DEPTH-1] = i_step & (~w_slotValid[DEPTH-1] | i_ready);
        for (int k = DEPTH - 2; k >= 0; k--) begin
            w_adv[k] = i_step & (~w_slotValid[k] | w_adv[k+1]);
        end
    end

    always_comb begin
        w_srcValid    = '0;
        w_srcValid[0] = w_inValid;
        w_srcCtrl[0]  = w_inCtrl;
        w_srcData[0]  = w_inData;
        for (int k = 1; k < DEPTH; k++) begin
            w_srcValid[k] = w_slotValid[k-1];
            w_srcCtrl[k]  = w_slotCtrl[k-1];
            w_srcData[k]  = w_slotData[k-1];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        pipe_stage_slot #(
            .NB_CTRL(NB_CTRL),
            .NB_DATA(NB_DATA)
        ) u_slot (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_load  (w_adv[k]),
            .i_bubble(i_flush),
            .i_valid (w_srcValid[k]),
            .i_ctrl  (w_srcCtrl[k]),
            .i_data  (w_srcData[k]),
            .o_valid (w_slotValid[k]),
            .o_ctrl  (w_slotCtrl[k]),
            .o_data  (w_slotData[k])
        );
    end

`ifdef PIPE_STAGE_SKID_EN
    logic               r_skidValid;
    logic [NB_CTRL-1:0] r_skidCtrl;
    logic [NB_DATA-1:0] r_skidData;
    logic               w_accept;

    assign o_ready     = i_step & ~r_skidValid;
    assign w_accept    = i_valid & o_ready & ~i_flush;
    assign w_inValid   = r_skidValid | w_accept;
    assign w_inCtrl    = r_skidValid ? r_skidCtrl : i_ctrl;
    assign w_inData    = r_skidValid ? r_skidData : i_data;
    assign w_skidValid = r_skidValid;

    // The skid entry catches an accepted word while slot 0 stalls and is always drained first.
    always_ff @(negedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_skidValid <= 1'b0;
            r_skidCtrl  <= '0;
            r_skidData  <= '0;
        end else if (i_flush) begin
            r_skidValid <= 1'b0;
            r_skidCtrl  <= NB_CTRL'(CTRL_BUBBLE);
        end else if (r_skidValid & w_adv[0]) begin
            r_skidValid <= 1'b0;
        end else if (w_accept & ~w_adv[0]) begin
            r_skidValid <= 1'b1;
            r_skidCtrl  <= i_ctrl;
            r_skidData  <= i_data;
        end
    end
`else
    assign o_ready     = w_adv[0];
    assign w_inValid   = i_valid & ~i_flush;
    assign w_inCtrl    = i_ctrl;
    assign w_inData    = i_data;
    assign w_skidValid = 1'b0;
`endif

    always_comb begin
        w_count = NB_COUNT'(w_skidValid);
        for (int k = 0; k < DEPTH; k++) begin
            w_count = w_count + NB_COUNT'(w_slotValid[k]);
        end
    end

    assign o_valid = w_slotValid[DEPTH-1];
    assign o_ctrl  = o_valid ? w_slotCtrl[DEPTH-1] : NB_CTRL'(CTRL_BUBBLE);
    assign o_data  = w_slotData[DEPTH-1];
    assign o_count = w_count;

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed bench for pipe_stage_buffer: DEPTH=2 by default, DEPTH=1 with skid when PIPE_STAGE_SKID_EN is defined.
module tb_pipe_stage_buffer;

`ifdef PIPE_STAGE_SKID_EN
    localparam int DEPTH = 1;
`else
    localparam int DEPTH = 2;
`endif
    localparam int CW = $clog2(DEPTH + 2);

    logic          i_clk;
    logic          i_reset;
    logic          i_step;
    logic          i_flush;
    logic          i_valid;
    logic          o_ready;
    logic [15:0]   i_ctrl;
    logic [95:0]   i_data;
    logic          o_valid;
    logic          i_ready;
    logic [15:0]   o_ctrl;
    logic [95:0]   o_data;
    logic [CW-1:0] o_count;

    int checks;
    int errors;

    pipe_stage_buffer #(
        .NB_CTRL(16),
        .NB_DATA(96),
        .DEPTH  (DEPTH)
    ) dut (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_step (i_step),
        .i_flush(i_flush),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_ctrl (i_ctrl),
        .i_data (i_data),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_ctrl (o_ctrl),
        .o_data (o_data),
        .o_count(o_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // State changes on the falling edge; the bench drives and samples just after the rising edge.
    task automatic tick;
        @(negedge i_clk);
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0h want 0", o_valid); end
        checks++; if (o_ctrl !== 16'h0) begin errors++; $display("[TB] FAIL reset_ctrl got %0h want 0", o_ctrl); end
        checks++; if (o_data !== 96'h0) begin errors++; $display("[TB] FAIL reset_data got %0h want 0", o_data); end
        checks++; if (o_count !== CW'(0)) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", o_count); end
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        i_ready = 1'b0;
        i_valid = 1'b1; i_ctrl = 16'h31; i_data = 96'h31;
        tick();
        i_ctrl = 16'h32; i_data = 96'h32;
        tick();
        i_valid = 1'b0;
        checks++; if (o_count !== CW'(2)) begin errors++; $display("[TB] FAIL midreset_pre_count got %0d want 2", o_count); end
        checks++; if (o_ctrl !== 16'h31) begin errors++; $display("[TB] FAIL midreset_pre_ctrl got %0h want 31", o_ctrl); end
        #2;
        i_reset = 1'b1;
        #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_valid got %0h want 0", o_valid); end
        checks++; if (o_ctrl !== 16'h0) begin errors++; $display("[TB] FAIL midreset_ctrl got %0h want 0", o_ctrl); end
        checks++; if (o_count !== CW'(0)) begin errors++; $display("[TB] FAIL midreset_count got %0d want 0", o_count); end
        i_reset = 1'b0;
        @(posedge i_clk);
        #1;
    endtask

`ifndef PIPE_STAGE_SKID_EN
    task automatic test_stream;
        int expV [5] = '{0, 1, 1, 1, 0};
        int expC [5] = '{0, 1, 2, 3, 0};
        int expN [5] = '{1, 2, 2, 1, 0};
        i_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            i_valid = (i < 3);
            i_ctrl  = 16'(i + 1);
            i_data  = 96'(256 + i + 1);
            tick();
            checks++; if (o_valid !== 1'(expV[i])) begin errors++; $display("[TB] FAIL stream_valid[%0d] got %0h want %0h", i, o_valid, expV[i]); end
            checks++; if (o_ctrl !== 16'(expC[i])) begin errors++; $display("[TB] FAIL stream_ctrl[%0d] got %0h want %0h", i, o_ctrl, expC[i]); end
            checks++; if (o_count !== CW'(expN[i])) begin errors++; $display("[TB] FAIL stream_count[%0d] got %0d want %0d", i, o_count, expN[i]); end
            if (expV[i] == 1) begin
                checks++; if (o_data !== 96'(256 + expC[i])) begin errors++; $display("[TB] FAIL stream_data[%0d] got %0h want %0h", i, o_data, 256 + expC[i]); end
            end
        end
        i_valid = 1'b0;
    endtask

    task automatic test_backpressure;
        i_ready = 1'b0;
        i_valid = 1'b1; i_ctrl = 16'h4; i_data = 96'h4;
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready0 got %0h want 1", o_ready); end
        tick();
        checks++; if (o_count !== CW'(1)) begin errors++; $display("[TB] FAIL bp_count1 got %0d want 1", o_count); end
        i_ctrl = 16'h5; i_data = 96'h5;
        tick();
        checks++; if (o_ctrl !== 16'h4) begin errors++; $display("[TB] FAIL bp_head got %0h want 4", o_ctrl); end
        i_ctrl = 16'h6; i_data = 96'h6;
        #1;
        checks++; if (o_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_full got %0h want 0", o_ready); end
        tick();
        checks++; if (o_ctrl !== 16'h4) begin errors++; $display("[TB] FAIL bp_hold_ctrl got %0h want 4", o_ctrl); end
        checks++; if (o_count !== CW'(2)) begin errors++; $display("[TB] FAIL bp_hold_count got %0d want 2", o_count); end
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        checks++; if (o_ctrl !== 16'h5) begin errors++; $display("[TB] FAIL bp_drain1 got %0h want 5", o_ctrl); end
        checks++; if (o_count !== CW'(1)) begin errors++; $display("[TB] FAIL bp_drain1_count got %0d want 1", o_count); end
        tick();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_empty got %0h want 0", o_valid); end
        checks++; if (o_count !== CW'(0)) begin errors++; $display("[TB] FAIL bp_empty_count got %0d want 0", o_count); end
    endtask

    task automatic test_flush;
        i_ready = 1'b0;
        i_valid = 1'b1; i_ctrl = 16'h7; i_data = 96'hABC;
        tick();
        i_ctrl = 16'h8;
        tick();
        checks++; if (o_count !== CW'(2)) begin errors++; $display("[TB] FAIL flush_pre_count got %0d want 2", o_count); end
        i_flush = 1'b1; i_ctrl = 16'h9; i_data = 96'h555; i_ready = 1'b1;
        tick();
        i_flush = 1'b0;
        i_valid = 1'b0;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid got %0h want 0", o_valid); end
        checks++; if (o_ctrl !== 16'h0) begin errors++; $display("[TB] FAIL flush_ctrl got %0h want 0", o_ctrl); end
        checks++; if (o_data !== 96'hABC) begin errors++; $display("[TB] FAIL flush_data got %0h want abc", o_data); end
        checks++; if (o_count !== CW'(0)) begin errors++; $display("[TB] FAIL flush_count got %0d want 0", o_count); end
        tick();
        checks++; if (o_count !== CW'(0)) begin errors++; $display("[TB] FAIL flush_discard got %0d want 0", o_count); end
    endtask

    task automatic test_step;
        i_ready = 1'b0;
        i_valid = 1'b1; i_ctrl = 16'h21; i_data = 96'h21;
        tick();
        i_ctrl = 16'h22; i_data = 96'h22;
        tick();
        i_step = 1'b0; i_ready = 1'b1; i_ctrl = 16'h23; i_data = 96'h23;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (o_ready !== 1'b0) begin errors++; $display("[TB] FAIL step_ready[%0d] got %0h want 0", i, o_ready); end
            tick();
            checks++; if (o_ctrl !== 16'h21) begin errors++; $display("[TB] FAIL step_ctrl[%0d] got %0h want 21", i, o_ctrl); end
            checks++; if (o_count !== CW'(2)) begin errors++; $display("[TB] FAIL step_count[%0d] got %0d want 2", i, o_count); end
        end
        i_step = 1'b1;
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("[TB] FAIL step_resume_ready got %0h want 1", o_ready); end
        tick();
        checks++; if (o_ctrl !== 16'h22) begin errors++; $display("[TB] FAIL step_resume1 got %0h want 22", o_ctrl); end
        checks++; if (o_count !== CW'(2)) begin errors++; $display("[TB] FAIL step_resume1_count got %0d want 2", o_count); end
        i_valid = 1'b0;
        tick();
        checks++; if (o_ctrl !== 16'h23) begin errors++; $display("[TB] FAIL step_resume2 got %0h want 23", o_ctrl); end
        checks++; if (o_data !== 96'h23) begin errors++; $display("[TB] FAIL step_resume2_data got %0h want 23", o_data); end
        tick();
        checks++; if (o_count !== CW'(0)) begin errors++; $display("[TB] FAIL step_final_count got %0d want 0", o_count); end
    endtask
`else
    task automatic test_skid;
        i_ready = 1'b0;
        i_valid = 1'b1; i_ctrl = 16'h41; i_data = 96'h41;
        tick();
        checks++; if (o_count !== CW'(1)) begin errors++; $display("[TB] FAIL skid_count1 got %0d want 1", o_count); end
        i_ctrl = 16'h42; i_data = 96'h42;
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("[TB] FAIL skid_ready1 got %0h want 1", o_ready); end
        tick();
        i_valid = 1'b0;
        #1;
        checks++; if (o_ready !== 1'b0) begin errors++; $display("[TB] FAIL skid_ready_full got %0h want 0", o_ready); end
        checks++; if (o_count !== CW'(2)) begin errors++; $display("[TB] FAIL skid_count2 got %0d want 2", o_count); end
        checks++; if (o_ctrl !== 16'h41) begin errors++; $display("[TB] FAIL skid_head got %0h want 41", o_ctrl); end
        i_ready = 1'b1;
        tick();
        checks++; if (o_ctrl !== 16'h42) begin errors++; $display("[TB] FAIL skid_second got %0h want 42", o_ctrl); end
        checks++; if (o_count !== CW'(1)) begin errors++; $display("[TB] FAIL skid_second_count got %0d want 1", o_count); end
        tick();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL skid_empty got %0h want 0", o_valid); end
        checks++; if (o_count !== CW'(0)) begin errors++; $display("[TB] FAIL skid_empty_count got %0d want 0", o_count); end
    endtask
`endif

    initial begin
        checks  = 0;
        errors  = 0;
        i_reset = 1'b1;
        i_step  = 1'b1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_ctrl  = '0;
        i_data  = '0;
        #2;
        test_reset();
`ifndef PIPE_STAGE_SKID_EN
        test_stream();
        test_backpressure();
        test_flush();
        test_step();
`else
        test_skid();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
